// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer.
// Holds the instruction layout, the opcode constants and mnemonics, the
// controller state encoding and the next-PC source selection.
package control_sequencer_pkg;

    localparam int INST_W  = 9;
    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 5;
    localparam int FLD_MSB = 4;
    localparam int FLD_LSB = 0;
    localparam int SUB_BIT = 4;

    localparam logic [3:0] kADD = 4'd0;
    localparam logic [3:0] kXOR = 4'd1;
    localparam logic [3:0] kLSB = 4'd2;
    localparam logic [3:0] kMSB = 4'd3;
    localparam logic [3:0] kLRS = 4'd4;
    localparam logic [3:0] kLDS = 4'd5;
    localparam logic [3:0] kGST = 4'd6;
    localparam logic [3:0] kACC = 4'd7;
    localparam logic [3:0] kENQ = 4'd8;
    localparam logic [3:0] kEQI = 4'd9;
    localparam logic [3:0] kBRC = 4'd10;
    localparam logic [3:0] kBRR = 4'd11;
    localparam logic [3:0] kOPA = 4'd12;
    localparam logic [3:0] kOPB = 4'd13;
    localparam logic [3:0] kOPC = 4'd14;
    localparam logic [3:0] kRST = 4'd15;

    typedef enum logic [3:0] {
        ADD = 4'd0,  XOR = 4'd1,  LSB = 4'd2,  MSB = 4'd3,
        LRS = 4'd4,  LDS = 4'd5,  GST = 4'd6,  ACC = 4'd7,
        ENQ = 4'd8,  EQI = 4'd9,  BRC = 4'd10, BRR = 4'd11,
        OPA = 4'd12, OPB = 4'd13, OPC = 4'd14, RST = 4'd15
    } op_mne;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_INC = 2'd0,
        PC_REL = 2'd1,
        PC_REG = 2'd2
    } pc_sel_e;

    // Opcodes 12..14 are reserved and trap as illegal.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == kOPA) || (op == kOPB) || (op == kOPC);
    endfunction

endpackage

// File: rtl/control_sequencer_pc_next.sv
// Next program counter computation.
// Ports:
//   pc_i        current program counter
//   field_i     instruction field, signed relative offset for PC_REL
//   reg_data_i  register read data, absolute target for PC_REG
//   sel_i       source select (increment, relative, register)
//   pc_next_o   next program counter, wraps modulo 2^PC_W
module pc_next_unit
    import control_sequencer_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [4:0]      field_i,
    input  logic [7:0]      reg_data_i,
    input  pc_sel_e         sel_i,
    output logic [PC_W-1:0] pc_next_o
);

    logic [PC_W-1:0] rel_off;
    logic [PC_W-1:0] reg_tgt;

    // Size casts: signed field sign-extends, unsigned reg data zero-extends,
    // both truncate when PC_W is narrower than the source.
    assign rel_off = PC_W'($signed(field_i));
    assign reg_tgt = PC_W'(reg_data_i);

    always_comb begin
        pc_next_o = pc_i + PC_W'(1);
        case (sel_i)
            PC_REL:  pc_next_o = pc_i + rel_off;
            PC_REG:  pc_next_o = reg_tgt;
            default: pc_next_o = pc_i + PC_W'(1);
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory wait and
// write-back, with a retired-instruction counter.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start_i             start a run from PC 0 (IDLE or HALT only)
//   inst_i              instruction at pc_o
//   cond_i              ALU condition flag for branches
//   reg_data_i          register read data, BRR target
//   mem_ack_i           data memory completion
//   pc_o                fetch address
//   alu_op_o            opcode of the held instruction
//   reg_we_o, acc_we_o, flag_we_o   write enables, WB only
//   mem_req_o, mem_we_o memory request / store
//   busy_o, done_o      running / halted
//   illegal_o           one-cycle pulse on a reserved opcode
//   retired_o           instructions retired since last start
//
// state  | meaning
// IDLE   | waiting for start_i after reset
// FETCH  | latch inst_i into the instruction register
// DECODE | present opcode, trap RST to HALT
// EXEC   | branches resolve, loads/stores go to MEM, ALU ops go to WB
// MEM    | memory request held until mem_ack_i
// WB     | single write-enable pulse, then next instruction
// HALT   | program finished, start_i restarts
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [8:0]        inst_i,
    input  logic              cond_i,
    input  logic [7:0]        reg_data_i,
    input  logic              mem_ack_i,
    output logic [PC_W-1:0]   pc_o,
    output op_mne             alu_op_o,
    output logic              reg_we_o,
    output logic              acc_we_o,
    output logic              flag_we_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  retired_o
);

    ctrl_state_e       state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  ret_q, ret_d;

    logic [3:0]        opcode;
    logic [4:0]        field;
    logic              sub;
    pc_sel_e           pc_sel;
    logic [PC_W-1:0]   pc_nxt;
    logic              to_fetch;
    logic              wb_acc;
    logic              wb_flag;

    assign opcode = ir_q[OPC_MSB:OPC_LSB];
    assign field  = ir_q[FLD_MSB:FLD_LSB];
    assign sub    = ir_q[SUB_BIT];

    pc_next_unit #(.PC_W(PC_W)) u_pc_next (
        .pc_i       (pc_q),
        .field_i    (field),
        .reg_data_i (reg_data_i),
        .sel_i      (pc_sel),
        .pc_next_o  (pc_nxt)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ret_d    = ret_q;
        pc_sel   = PC_INC;
        to_fetch = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    pc_d    = '0;
                    ret_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = inst_i;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = (opcode == kRST) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (opcode == kLDS) begin
                    state_d = ST_MEM;
                end else if (opcode == kBRC) begin
                    pc_sel   = cond_i ? PC_REL : PC_INC;
                    pc_d     = pc_nxt;
                    to_fetch = 1'b1;
                end else if (opcode == kBRR) begin
                    pc_sel   = cond_i ? PC_REG : PC_INC;
                    pc_d     = pc_nxt;
                    to_fetch = 1'b1;
                end else if (is_illegal(opcode)) begin
                    pc_d     = pc_nxt;
                    to_fetch = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ack_i) begin
                    if (sub) begin
                        pc_d     = pc_nxt;
                        to_fetch = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                pc_d     = pc_nxt;
                to_fetch = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (to_fetch) begin
            state_d = ST_FETCH;
            ret_d   = ret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ret_q   <= ret_d;
        end
    end

    // Exactly one enable in WB: accumulator, flag, otherwise register file.
    assign wb_acc  = (opcode == kACC) || ((opcode == kGST) && sub);
    assign wb_flag = (opcode == kENQ) || (opcode == kEQI);

    assign acc_we_o  = (state_q == ST_WB) && wb_acc;
    assign flag_we_o = (state_q == ST_WB) && wb_flag;
    assign reg_we_o  = (state_q == ST_WB) && !wb_acc && !wb_flag;

    assign mem_req_o = (state_q == ST_MEM);
    assign mem_we_o  = (state_q == ST_MEM) && sub;
    assign illegal_o = (state_q == ST_EXEC) && is_illegal(opcode);
    assign done_o    = (state_q == ST_HALT);
    assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_HALT);

    assign pc_o      = pc_q;
    assign alu_op_o  = op_mne'(opcode);
    assign retired_o = ret_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, start2;
    logic        cond_i;
    logic [7:0]  reg_data_i;
    logic        mem_ack_i;

    logic [8:0]  inst_i, inst2;
    logic [9:0]  pc_o;
    op_mne       alu_op_o, alu_op2;
    logic        reg_we_o, acc_we_o, flag_we_o, mem_req_o, mem_we_o;
    logic        busy_o, done_o, illegal_o;
    logic [15:0] retired_o;

    logic [3:0]  pc2;
    logic        reg_we2, acc_we2, flag_we2, mem_req2, mem_we2;
    logic        busy2, done2, illegal2;
    logic [15:0] retired2;

    logic [8:0]  rom  [0:1023];
    logic [8:0]  rom2 [0:15];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign inst_i = rom[pc_o];
    assign inst2  = rom2[pc2];

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .inst_i(inst_i),
        .cond_i(cond_i), .reg_data_i(reg_data_i), .mem_ack_i(mem_ack_i),
        .pc_o(pc_o), .alu_op_o(alu_op_o), .reg_we_o(reg_we_o),
        .acc_we_o(acc_we_o), .flag_we_o(flag_we_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .busy_o(busy_o), .done_o(done_o),
        .illegal_o(illegal_o), .retired_o(retired_o)
    );

    control_sequencer #(.PC_W(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .inst_i(inst2),
        .cond_i(cond_i), .reg_data_i(reg_data_i), .mem_ack_i(mem_ack_i),
        .pc_o(pc2), .alu_op_o(alu_op2), .reg_we_o(reg_we2),
        .acc_we_o(acc_we2), .flag_we_o(flag_we2), .mem_req_o(mem_req2),
        .mem_we_o(mem_we2), .busy_o(busy2), .done_o(done2),
        .illegal_o(illegal2), .retired_o(retired2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_en(input string tag, input logic r, input logic a, input logic f);
        chk({tag, " reg_we"},  {31'd0, reg_we_o},  {31'd0, r});
        chk({tag, " acc_we"},  {31'd0, acc_we_o},  {31'd0, a});
        chk({tag, " flag_we"}, {31'd0, flag_we_o}, {31'd0, f});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From FETCH: DECODE, EXEC, WB (check enables), then back in FETCH.
    task automatic alu_instr(input string tag, input op_mne op, input logic r,
                             input logic a, input logic f,
                             input int exp_pc, input int exp_ret);
        step();
        chk({tag, " decode op"}, {28'd0, alu_op_o}, {28'd0, op});
        chk_en({tag, " decode"}, 1'b0, 1'b0, 1'b0);
        step();
        chk_en({tag, " exec"}, 1'b0, 1'b0, 1'b0);
        step();
        chk_en({tag, " wb"}, r, a, f);
        step();
        chk_en({tag, " fetch"}, 1'b0, 1'b0, 1'b0);
        chk({tag, " pc"}, {22'd0, pc_o}, exp_pc);
        chk({tag, " retired"}, {16'd0, retired_o}, exp_ret);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        for (int i = 0; i < 16; i++) rom2[i] = 9'h000;
        rom[0]  = 9'h000;   // ADD
        rom[1]  = 9'h0E0;   // ACC
        rom[2]  = 9'h100;   // ENQ
        rom[3]  = 9'h0D0;   // GST, field[4]=1 -> accumulator
        rom[4]  = 9'h0A0;   // LDS load
        rom[5]  = 9'h15E;   // BRC offset -2
        rom[6]  = 9'h0B0;   // LDS store
        rom[7]  = 9'h160;   // BRR
        rom[10] = 9'h180;   // reserved opcode 12
        rom[11] = 9'h1E0;   // RST
        rom2[0]  = 9'h160;  // BRR
        rom2[15] = 9'h020;  // XOR

        rst_n = 1'b0; start_i = 1'b0; start2 = 1'b0; cond_i = 1'b0;
        reg_data_i = 8'h00; mem_ack_i = 1'b0;
        #2;
        chk("rst pc", {22'd0, pc_o}, 32'd0);
        chk("rst retired", {16'd0, retired_o}, 32'd0);
        chk("rst busy", {31'd0, busy_o}, 32'd0);
        chk("rst done", {31'd0, done_o}, 32'd0);
        chk("rst alu_op", {28'd0, alu_op_o}, {28'd0, ADD});
        chk("rst mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst illegal", {31'd0, illegal_o}, 32'd0);
        chk_en("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle busy", {31'd0, busy_o}, 32'd0);

        // ADD at PC 0, with a stray mem_ack that must be ignored
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        mem_ack_i = 1'b1;
        chk("start busy", {31'd0, busy_o}, 32'd1);
        chk("start pc", {22'd0, pc_o}, 32'd0);
        alu_instr("add", ADD, 1'b1, 1'b0, 1'b0, 1, 1);
        mem_ack_i = 1'b0;

        alu_instr("acc", ACC, 1'b0, 1'b1, 1'b0, 2, 2);
        alu_instr("enq", ENQ, 1'b0, 1'b0, 1'b1, 3, 3);
        alu_instr("gst", GST, 1'b0, 1'b1, 1'b0, 4, 4);

        // Load, ack after three wait cycles
        step(); step(); step();
        for (int i = 0; i < 4; i++) begin
            chk("ld wait req", {31'd0, mem_req_o}, 32'd1);
            chk("ld wait we", {31'd0, mem_we_o}, 32'd0);
            chk("ld wait pc", {22'd0, pc_o}, 32'd4);
            chk_en("ld wait", 1'b0, 1'b0, 1'b0);
            if (i == 3) mem_ack_i = 1'b1;
            step();
        end
        mem_ack_i = 1'b0;
        chk("ld wb req", {31'd0, mem_req_o}, 32'd0);
        chk_en("ld wb", 1'b1, 1'b0, 1'b0);
        step();
        chk_en("ld fetch", 1'b0, 1'b0, 1'b0);
        chk("ld pc", {22'd0, pc_o}, 32'd5);
        chk("ld retired", {16'd0, retired_o}, 32'd5);

        // BRC taken: 5 + (-2) = 3
        cond_i = 1'b1;
        step(); step();
        chk_en("brc exec", 1'b0, 1'b0, 1'b0);
        chk("brc mem_req", {31'd0, mem_req_o}, 32'd0);
        step();
        chk("brc taken pc", {22'd0, pc_o}, 32'd3);
        chk("brc taken retired", {16'd0, retired_o}, 32'd6);
        cond_i = 1'b0;

        alu_instr("gst2", GST, 1'b0, 1'b1, 1'b0, 4, 7);

        // Load, immediate ack
        mem_ack_i = 1'b1;
        step(); step(); step();
        chk("ld0 req", {31'd0, mem_req_o}, 32'd1);
        step();
        mem_ack_i = 1'b0;
        chk_en("ld0 wb", 1'b1, 1'b0, 1'b0);
        step();
        chk("ld0 pc", {22'd0, pc_o}, 32'd5);

        // BRC not taken
        step(); step(); step();
        chk("brc nt pc", {22'd0, pc_o}, 32'd6);
        chk("brc nt retired", {16'd0, retired_o}, 32'd9);

        // Store, immediate ack
        mem_ack_i = 1'b1;
        step(); step(); step();
        chk("st req", {31'd0, mem_req_o}, 32'd1);
        chk("st we", {31'd0, mem_we_o}, 32'd1);
        chk_en("st mem", 1'b0, 1'b0, 1'b0);
        step();
        mem_ack_i = 1'b0;
        chk_en("st fetch", 1'b0, 1'b0, 1'b0);
        chk("st pc", {22'd0, pc_o}, 32'd7);
        chk("st retired", {16'd0, retired_o}, 32'd10);

        // BRR taken to register value
        cond_i = 1'b1;
        reg_data_i = 8'h0A;
        step(); step(); step();
        cond_i = 1'b0;
        chk("brr pc", {22'd0, pc_o}, 32'd10);
        chk("brr retired", {16'd0, retired_o}, 32'd11);

        // Reserved opcode
        step(); step();
        chk("ill pulse", {31'd0, illegal_o}, 32'd1);
        chk_en("ill exec", 1'b0, 1'b0, 1'b0);
        step();
        chk("ill clear", {31'd0, illegal_o}, 32'd0);
        chk_en("ill fetch", 1'b0, 1'b0, 1'b0);
        chk("ill pc", {22'd0, pc_o}, 32'd11);
        chk("ill retired", {16'd0, retired_o}, 32'd12);

        // RST halts
        step();
        chk("rst op", {28'd0, alu_op_o}, {28'd0, RST});
        step();
        chk("halt done", {31'd0, done_o}, 32'd1);
        chk("halt busy", {31'd0, busy_o}, 32'd0);
        chk("halt retired", {16'd0, retired_o}, 32'd12);
        step();
        chk("halt stays", {31'd0, done_o}, 32'd1);

        // Restart from HALT into a load that gets reset mid-wait
        rom[0] = 9'h0A0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("restart pc", {22'd0, pc_o}, 32'd0);
        chk("restart retired", {16'd0, retired_o}, 32'd0);
        chk("restart done", {31'd0, done_o}, 32'd0);
        step(); step(); step();
        chk("abort in mem", {31'd0, mem_req_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("abort busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack_i = 1'b1;
        step();
        chk_en("late ack", 1'b0, 1'b0, 1'b0);
        chk("late ack busy", {31'd0, busy_o}, 32'd0);
        chk("late ack mem_req", {31'd0, mem_req_o}, 32'd0);
        mem_ack_i = 1'b0;

        // PC_W=4: BRR to 0xFF truncates to 15, then XOR wraps to 0
        cond_i = 1'b1;
        reg_data_i = 8'hFF;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step(); step(); step();
        cond_i = 1'b0;
        chk("w4 brr pc", {28'd0, pc2}, 32'd15);
        step(); step(); step();
        chk("w4 xor wb", {31'd0, reg_we2}, 32'd1);
        step();
        chk("w4 wrap pc", {28'd0, pc2}, 32'd0);
        chk("w4 retired", {16'd0, retired2}, 32'd2);
        chk("main idle", {31'd0, busy_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
